// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage
//   IF/ID pipeline stage with a valid/ready handshake on both sides. Two entries
//   of storage (main + skid) allow one beat per cycle while in_ready stays a
//   pure register output. flush empties the stage. stall_cnt is a saturating
//   count of cycles in which decode refused a valid beat.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   fetch-side handshake (in_ready registered)
//   pc_in, pc_plus_4_in, inst_in   fetch payload
//   flush               drop every held and incoming beat this cycle
//   out_valid/out_ready decode-side handshake (out_valid registered)
//   pc_out, pc_plus_4_out, inst_out  payload of the head entry
//                                    (inst_out is NOP_INST while empty)
//   occupancy           entries held, 0..2
//   stall_cnt           saturating count of out_valid & ~out_ready cycles
module if_id_skid_stage #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter logic [ILEN-1:0] NOP_INST = 32'h0000_0013,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  pc_in,
   input  logic [XLEN-1:0]  pc_plus_4_in,
   input  logic [ILEN-1:0]  inst_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  pc_out,
   output logic [XLEN-1:0]  pc_plus_4_out,
   output logic [ILEN-1:0]  inst_out,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [ILEN-1:0] inst;
   } beat_t;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam beat_t CLR_BEAT = '{pc: '0, pc4: '0, inst: NOP_INST};

   state_t state;
   beat_t  main_q;
   beat_t  skid_q;
   beat_t  in_beat;
   logic   in_fire;
   logic   out_fire;

   assign in_beat  = '{pc: pc_in, pc4: pc_plus_4_in, inst: inst_in};

   // Both handshake flags are decoded straight from the state register, so
   // neither has a combinational path from out_ready or flush.
   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != FULL);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign occupancy     = state;
   assign pc_out        = main_q.pc;
   assign pc_plus_4_out = main_q.pc4;
   assign inst_out      = out_valid ? main_q.inst : NOP_INST;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= EMPTY;
         main_q    <= CLR_BEAT;
         skid_q    <= CLR_BEAT;
         stall_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;

         if (flush) begin
            // Any beat accepted this cycle is discarded; skid is left stale.
            state  <= EMPTY;
            main_q <= CLR_BEAT;
         end else begin
            case (state)
               EMPTY: if (in_fire) begin
                  main_q <= in_beat;
                  state  <= BUSY;
               end
               BUSY: case ({in_fire, out_fire})
                  2'b11: main_q <= in_beat;
                  2'b10: begin
                     skid_q <= in_beat;
                     state  <= FULL;
                  end
                  // main keeps its payload; inst_out is masked while EMPTY.
                  2'b01: state <= EMPTY;
                  default: ;
               endcase
               FULL: if (out_fire) begin
                  main_q <= skid_q;
                  state  <= BUSY;
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Testbench for if_id_skid_stage: directed scenarios followed by a random
// phase. The reference model is a FIFO queue of accepted beats: its size is
// the expected occupancy, and its head is the expected output beat.
module tb_if_id_skid_stage;
   localparam int          XLEN  = 32;
   localparam int          ILEN  = 32;
   localparam int          CNT_W = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          SAT   = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b1;
   logic             in_ready;
   logic [XLEN-1:0]  pc_in = '0;
   logic [XLEN-1:0]  pc_plus_4_in = '0;
   logic [ILEN-1:0]  inst_in = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [XLEN-1:0]  pc_out;
   logic [XLEN-1:0]  pc_plus_4_out;
   logic [ILEN-1:0]  inst_out;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;

   if_id_skid_stage #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .pc_plus_4_in(pc_plus_4_in), .inst_in(inst_in),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .pc_plus_4_out(pc_plus_4_out), .inst_out(inst_out),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
   } beat_t;

   beat_t q[$];
   int    total = 0;
   int    bad = 0;
   int    exp_stall = 0;
   bit    took = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stimulus side: record each handshaken beat into the expected queue.
   always @(negedge clk) begin
      #1;
      took = 1'b0;
      if (rst && in_valid && in_ready) begin
         took = 1'b1;
         if (!flush) q.push_back('{pc_in, pc_plus_4_in, inst_in});
      end
   end

   // Monitor: compare held state against the queue, pop on delivery.
   always @(negedge clk) begin
      beat_t b;
      chk("occupancy", occupancy, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("stall_cnt", stall_cnt, exp_stall);
      if (q.size() == 0) chk("inst_nop", inst_out, NOP);
      if (!rst) begin
         q.delete();
         exp_stall = 0;
      end else begin
         if (q.size() != 0 && !out_ready && exp_stall < SAT) exp_stall++;
         if (q.size() != 0 && out_ready) begin
            b = q.pop_front();
            chk("pc_out", pc_out, b.pc);
            chk("pc4_out", pc_plus_4_out, b.pc4);
            chk("inst_out", inst_out, b.inst);
         end
         if (flush) q.delete();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] inst);
      in_valid = 1'b1;
      pc_in = pc;
      pc_plus_4_in = pc + 32'd4;
      inst_in = inst;
      for (int i = 0; i < 50; i++) begin
         step();
         if (took) begin
            in_valid = 1'b0;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL send_timeout: pc %0h never accepted", pc);
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset with in_valid high: the beat must be ignored.
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_inst_out", inst_out, NOP);
      chk("rst_stall", stall_cnt, 0);
      rst = 1'b1;
      in_valid = 1'b0;
      step();

      // Streaming.
      out_ready = 1'b1;
      send(32'h100, 32'hA);
      send(32'h104, 32'hB);
      send(32'h108, 32'hC);
      step(); step();

      // Backpressure into FULL, then drain.
      out_ready = 1'b0;
      send(32'h200, 32'h20);
      send(32'h204, 32'h24);
      chk("bp_occupancy", occupancy, 2);
      chk("bp_pc_out", pc_out, 32'h200);
      step(); step();
      out_ready = 1'b1;
      step(); step(); step();

      // Flush while FULL with a beat waiting at the input.
      out_ready = 1'b0;
      send(32'h2A0, 32'h2A);
      send(32'h2A4, 32'h2B);
      in_valid = 1'b1; pc_in = 32'h300; pc_plus_4_in = 32'h304; inst_in = 32'h30;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_out_valid", out_valid, 0);
      chk("fl_occupancy", occupancy, 0);
      chk("fl_pc_out", pc_out, 0);
      chk("fl_pc4_out", pc_plus_4_out, 0);
      chk("fl_inst_out", inst_out, NOP);
      chk("fl_in_ready", in_ready, 1);
      out_ready = 1'b1;
      step(); step();

      // Saturation of stall_cnt, survives flush, cleared by reset.
      out_ready = 1'b0;
      send(32'h500, 32'h50);
      for (int i = 0; i < 20; i++) step();
      chk("sat_stall", stall_cnt, SAT);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("sat_after_flush", stall_cnt, SAT);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("sat_after_rst", stall_cnt, 0);

      // Reset mid-stream from FULL, then a fresh beat.
      send(32'h600, 32'h60);
      send(32'h604, 32'h64);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mr_occupancy", occupancy, 0);
      chk("mr_pc_out", pc_out, 0);
      chk("mr_inst_out", inst_out, NOP);
      out_ready = 1'b1;
      send(32'h400, 32'h40);
      chk("mr_out_valid", out_valid, 1);
      chk("mr_pc_out_new", pc_out, 32'h400);
      step();

      // Random phase.
      for (int c = 0; c < 3000; c++) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            pc_in = $urandom;
            pc_plus_4_in = pc_in + 32'd4;
            inst_in = $urandom;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 40) == 0);
         rst = ($urandom_range(0, 150) != 0);
         step();
      end
      flush = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
